// File: rtl/vedic_multiplier_16bit_pkg.sv
// Shared widths and Urdhva 2x2/4x4 building blocks.
// Used by vedic_mul8 and the 16-bit top.
package vedic_multiplier_16bit_pkg;

  localparam int OP_W   = 16;
  localparam int PROD_W = 32;
  localparam int HALF_W = 8;

  // 2x2 cell: AND terms plus two half adders.
  function automatic logic [3:0] vmul2(
    input logic [1:0] a,
    input logic [1:0] b
  );
    logic t0, t1, t2, t3, c1;
    logic [3:0] p;
    t0 = a[0] & b[0];
    t1 = a[1] & b[0];
    t2 = a[0] & b[1];
    t3 = a[1] & b[1];
    c1 = t1 & t2;
    p[0] = t0;
    p[1] = t1 ^ t2;
    p[2] = t3 ^ c1;
    p[3] = t3 & c1;
    return p;
  endfunction

  // 4x4 from four 2x2 cells, vertical-and-crosswise.
  function automatic logic [7:0] vmul4(
    input logic [3:0] a,
    input logic [3:0] b
  );
    logic [3:0] ll, hl, lh, hh;
    logic [4:0] mid;
    logic [5:0] hi;
    ll  = vmul2(a[1:0], b[1:0]);
    hl  = vmul2(a[3:2], b[1:0]);
    lh  = vmul2(a[1:0], b[3:2]);
    hh  = vmul2(a[3:2], b[3:2]);
    mid = {1'b0, hl} + {1'b0, lh};
    // ll[1:0] is final; the rest shares weight 2^2.
    hi  = {hh, ll[3:2]} + {1'b0, mid};
    return {hi, ll[1:0]};
  endfunction

endpackage

// File: rtl/vedic_mul8.sv
// Unsigned 8x8 -> 16 Urdhva multiplier.
// Ports: a, b (8-bit operands), p (16-bit product).
module vedic_mul8
  import vedic_multiplier_16bit_pkg::*;
(
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  logic [7:0]  ll, hl, lh, hh;
  logic [8:0]  mid;
  logic [11:0] hi;

  always_comb begin
    ll  = vmul4(a[3:0], b[3:0]);
    hl  = vmul4(a[7:4], b[3:0]);
    lh  = vmul4(a[3:0], b[7:4]);
    hh  = vmul4(a[7:4], b[7:4]);
    mid = {1'b0, hl} + {1'b0, lh};
    // ll[3:0] is final; upper bits share weight 2^4.
    hi  = {hh, ll[7:4]} + {3'b000, mid};
    p   = {hi, ll[3:0]};
  end

endmodule

// File: rtl/vedic_multiplier_16bit.sv
// Exact 16x16 Urdhva multiplier, registered product.
// Ports: clk, rst_n (async low), in1, in2 (16b), out (32b).
module vedic_multiplier_16bit
  import vedic_multiplier_16bit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  output logic [31:0] out
);

  logic [15:0] pp_ll, pp_hl, pp_lh, pp_hh;
  logic [16:0] mid;
  logic [23:0] hi;
  logic [31:0] prod;

  vedic_mul8 u_ll (
    .a (in1[HALF_W-1:0]),
    .b (in2[HALF_W-1:0]),
    .p (pp_ll)
  );

  vedic_mul8 u_hl (
    .a (in1[OP_W-1:HALF_W]),
    .b (in2[HALF_W-1:0]),
    .p (pp_hl)
  );

  vedic_mul8 u_lh (
    .a (in1[HALF_W-1:0]),
    .b (in2[OP_W-1:HALF_W]),
    .p (pp_lh)
  );

  vedic_mul8 u_hh (
    .a (in1[OP_W-1:HALF_W]),
    .b (in2[OP_W-1:HALF_W]),
    .p (pp_hh)
  );

  always_comb begin
    mid  = {1'b0, pp_hl} + {1'b0, pp_lh};
    // ll[7:0] bypasses; the rest sums at weight 2^8.
    hi   = {pp_hh, pp_ll[15:8]} + {7'd0, mid};
    prod = {hi, pp_ll[7:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out <= '0;
    else        out <= prod;
  end

endmodule

// File: tb/tb_vedic_multiplier_16bit.sv
// Bench for vedic_multiplier_16bit.
// Directed table, random stream, async reset, 8-bit sweep.
module tb_vedic_multiplier_16bit;

  logic        clk;
  logic        rst_n;
  logic [15:0] in1;
  logic [15:0] in2;
  logic [31:0] out;

  int total;
  int bad;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  vedic_multiplier_16bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in1   (in1),
    .in2   (in2),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      if (bad < 30)
        $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic apply(
    input logic [15:0] a,
    input logic [15:0] b
  );
    @(negedge clk);
    in1 = a;
    in2 = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    vecs[0] = '{"ones",   16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
    vecs[1] = '{"zero",   16'h0000, 16'hABCD, 32'h0000_0000};
    vecs[2] = '{"one",    16'h0001, 16'hABCD, 32'h0000_ABCD};
    vecs[3] = '{"msb",    16'h8000, 16'h0002, 32'h0001_0000};
    vecs[4] = '{"xhalf1", 16'h00FF, 16'hFF00, 32'h00FE_0100};
    vecs[5] = '{"xhalf2", 16'h0100, 16'h0100, 32'h0001_0000};
    vecs[6] = '{"mix",    16'h1234, 16'h5678, 32'h0626_0060};
    vecs[7] = '{"hipow",  16'h8000, 16'h8000, 32'h4000_0000};
    vecs[8] = '{"loff",   16'hFFFF, 16'h0001, 32'h0000_FFFF};
    vecs[9] = '{"sq255",  16'h00FF, 16'h00FF, 32'h0000_FE01};

    // reset hold
    rst_n = 1'b0;
    in1   = 16'd782;
    in2   = 16'd767;
    #1;
    chk("rst_async", out, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_hold", out, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_release", out, 32'd599794);

    // directed table
    foreach (vecs[i]) begin
      apply(vecs[i].a, vecs[i].b);
      chk(vecs[i].name, out, vecs[i].exp);
    end

    // back-to-back random stream
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = 16'($urandom);
      apply(a, b);
      chk("rand", out, 32'(a) * 32'(b));
    end

    // async reset between edges
    apply(16'hFFFF, 16'hFFFF);
    chk("pre_rst", out, 32'hFFFE_0001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst", out, 32'd0);
    in1 = 16'd3;
    in2 = 16'd5;
    @(posedge clk);
    #1;
    chk("mid_rst_hold", out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_rel", out, 32'd15);

    // 8-bit exhaustive sweep
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        apply(16'(a), 16'(b));
        chk("sweep8", out, 32'(a * b));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
